// File: rtl/addr_decoder_n.sv
// addr_decoder_n: shifts a serial address in either bit order, matches it against base/size
// windows, grants the highest-index hit and holds it until the bus releases that target.
module addr_decoder_n #(
    parameter int NUM_TARGETS = 4,
    parameter int ADDR_WIDTH = 16,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_BASE = {16'hC000, 16'h8000, 16'h4000, 16'h0000},
    parameter logic [NUM_TARGETS*32-1:0] TARGET_SIZE = {32'd16384, 32'd4096, 32'd4096, 32'd2048},
    parameter bit MSB_FIRST = 1'b0,
    localparam int SEL_W = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bus_data_in,
    input  logic                   bus_data_in_valid,
    input  logic                   bus_mode,
    input  logic [NUM_TARGETS-1:0] release_valids,
    output logic [NUM_TARGETS-1:0] target_valid,
    output logic [SEL_W-1:0]       sel,
    output logic                   decode_err,
    output logic                   busy
);
    localparam int CW = $clog2(ADDR_WIDTH + 1);
    localparam int XW = ADDR_WIDTH + 33;
    localparam logic [CW-1:0] LAST = CW'(ADDR_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  sr_q, sr_d, sr_shift;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_TARGETS-1:0] tv_q, tv_d, hit;
    logic [SEL_W-1:0]       sel_q, sel_d, hit_idx;
    logic                   err_q, err_d;
    logic                   take;

    assign take     = bus_data_in_valid && !bus_mode;
    assign sr_shift = MSB_FIRST ? {sr_q[ADDR_WIDTH-2:0], bus_data_in}
                                : {bus_data_in, sr_q[ADDR_WIDTH-1:1]};

    // Wide compare keeps base+size from wrapping at the top of the address space
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (TARGET_SIZE[i*32 +: 32] != 32'd0
                && XW'(sr_q) >= XW'(TARGET_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
                && XW'(sr_q) < XW'(TARGET_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) + XW'(TARGET_SIZE[i*32 +: 32])) begin
                hit[i]  = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        tv_d    = tv_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    sr_d    = sr_shift;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!take) begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    sr_d    = sr_shift;
                    cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == LAST ? DECODE : SHIFT;
                end
            end
            DECODE: begin
                sr_d    = '0;
                tv_d    = |hit ? NUM_TARGETS'(1) << hit_idx : '0;
                sel_d   = |hit ? hit_idx : '0;
                err_d   = ~|hit;
                state_d = |hit ? HOLD : IDLE;
            end
            HOLD: begin
                if (|(release_valids & tv_q)) begin
                    tv_d    = '0;
                    sel_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            tv_q    <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            tv_q    <= tv_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign target_valid = tv_q;
    assign sel          = sel_q;
    assign decode_err   = err_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_addr_decoder_n.sv
// tb_addr_decoder_n: four decoder configurations on one shared bus, each checked every cycle
// against an address-arithmetic model, plus directed literal expectations.
module tb_addr_decoder_n;
    logic clk = 1'b0, rst_n = 1'b0, din = 1'b0, vld = 1'b0, mode = 1'b0;
    logic [3:0] rel = '0;
    logic [3:0][3:0] tv;
    logic [3:0][1:0] sl;
    logic [3:0] er, bz;
    int total = 0, passed = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    addr_decoder_n u0 (.clk(clk), .rst_n(rst_n), .bus_data_in(din), .bus_data_in_valid(vld), .bus_mode(mode),
        .release_valids(rel), .target_valid(tv[0]), .sel(sl[0]), .decode_err(er[0]), .busy(bz[0]));
    addr_decoder_n #(.TARGET_BASE({16'hC000, 16'h8000, 16'h0000, 16'h0000})) u1 (.clk(clk), .rst_n(rst_n),
        .bus_data_in(din), .bus_data_in_valid(vld), .bus_mode(mode), .release_valids(rel),
        .target_valid(tv[1]), .sel(sl[1]), .decode_err(er[1]), .busy(bz[1]));
    addr_decoder_n #(.ADDR_WIDTH(12), .TARGET_BASE({12'hC00, 12'h800, 12'h400, 12'h000}),
        .TARGET_SIZE({4{32'h400}}), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus_data_in(din),
        .bus_data_in_valid(vld), .bus_mode(mode), .release_valids(rel),
        .target_valid(tv[2]), .sel(sl[2]), .decode_err(er[2]), .busy(bz[2]));
    addr_decoder_n #(.ADDR_WIDTH(12), .TARGET_BASE({12'hC00, 12'h800, 12'h400, 12'h000}),
        .TARGET_SIZE({4{32'h400}}), .MSB_FIRST(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .bus_data_in(din),
        .bus_data_in_valid(vld), .bus_mode(mode), .release_valids(rel),
        .target_valid(tv[3]), .sel(sl[3]), .decode_err(er[3]), .busy(bz[3]));

    function automatic longint base_of(int k, int i);
        return (k == 1 && i < 2) ? 0 : (k < 2 ? i * 'h4000 : i * 'h400);
    endfunction

    function automatic longint size_of(int k, int i);
        return k >= 2 ? 'h400 : (i == 0 ? 2048 : (i == 3 ? 16384 : 4096));
    endfunction

    // Model: bits collected so far, address accumulated arithmetically, then granted index or -1
    int nb [4];
    longint acc [4];
    bit pend [4];
    int gnt [4];
    bit merr [4];

    always @(posedge clk or negedge rst_n) begin : model
        int w, best;
        for (int k = 0; k < 4; k++) begin
            w = k < 2 ? 16 : 12;
            if (!rst_n) begin
                nb[k] = 0; acc[k] = 0; pend[k] = 0; gnt[k] = -1; merr[k] = 0;
            end else begin
                merr[k] = 0;
                if (gnt[k] >= 0) begin
                    if (rel[gnt[k]]) gnt[k] = -1;
                end else if (pend[k]) begin
                    best = -1;
                    for (int i = 0; i < 4; i++)
                        if (size_of(k, i) != 0 && acc[k] >= base_of(k, i) && acc[k] < base_of(k, i) + size_of(k, i))
                            best = i;
                    gnt[k] = best;
                    merr[k] = best < 0;
                    pend[k] = 0;
                    acc[k] = 0;
                end else if (vld && !mode) begin
                    acc[k] = k == 2 ? acc[k] * 2 + longint'(din) : acc[k] + (longint'(din) << nb[k]);
                    nb[k]++;
                    if (nb[k] == w) begin
                        pend[k] = 1;
                        nb[k] = 0;
                    end
                end else begin
                    nb[k] = 0;
                    acc[k] = 0;
                end
            end
        end
    end

    task automatic chk(string n, int a, int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("model_tv%0d", k), int'(tv[k]), gnt[k] >= 0 ? 1 << gnt[k] : 0);
                chk($sformatf("model_sel%0d", k), int'(sl[k]), gnt[k] >= 0 ? gnt[k] : 0);
                chk($sformatf("model_err%0d", k), int'(er[k]), int'(merr[k]));
                chk($sformatf("model_busy%0d", k), int'(bz[k]), int'(nb[k] > 0 || pend[k] || gnt[k] >= 0));
            end
        end
    end

    task automatic neg(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(int w, logic [31:0] a, bit msb);
        for (int j = 0; j < w; j++) begin
            @(posedge clk); #1;
            vld = 1'b1;
            din = msb ? a[w-1-j] : a[j];
        end
        @(posedge clk); #1;
        vld = 1'b0;
        din = 1'b0;
    endtask

    task automatic rls(logic [3:0] r);
        @(posedge clk); #1;
        rel = r;
        @(posedge clk); #1;
        rel = '0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        chk("rst_tv", int'(tv[0]), 0);
        chk("rst_sel", int'(sl[0]), 0);
        chk("rst_err", int'(er[0]), 0);
        chk("rst_busy", int'(bz[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(16, 'h4010, 1'b0); neg(2);
        chk("a4010_tv", int'(tv[0]), 2);
        chk("a4010_sel", int'(sl[0]), 1);
        chk("a4010_ovl_err", int'(er[1]), 1);
        rls(4'b0010); neg(1);
        chk("rel_tv", int'(tv[0]), 0);
        chk("rel_sel", int'(sl[0]), 0);
        chk("rel_busy", int'(bz[0]), 0);

        send(16, 'hFFFF, 1'b0); neg(2);
        chk("top_tv", int'(tv[0]), 8);
        chk("top_sel", int'(sl[0]), 3);
        rls(4'b1000);

        send(16, 'h0800, 1'b0); neg(1);
        chk("unmap_err_decode", int'(er[0]), 0);
        neg(1);
        chk("unmap_err", int'(er[0]), 1);
        chk("unmap_tv", int'(tv[0]), 0);
        neg(1);
        chk("unmap_err_pulse", int'(er[0]), 0);

        send(16, 'h0800, 1'b0);
        send(16, 'h4010, 1'b0); neg(2);
        chk("b2b_tv", int'(tv[0]), 2);
        rls(4'hF);

        send(16, 'h0100, 1'b0); neg(2);
        chk("ovl_tv", int'(tv[1]), 2);
        chk("ovl_sel", int'(sl[1]), 1);
        chk("ovl_dflt_tv", int'(tv[0]), 1);
        rls(4'hF);

        for (int j = 0; j < 9; j++) begin
            @(posedge clk); #1;
            vld = 1'b1;
            din = j[0];
        end
        @(posedge clk); #1;
        vld = 1'b0;
        neg(2);
        chk("abort_busy", int'(bz[0]), 0);
        chk("abort_tv", int'(tv[0]), 0);
        chk("abort_err", int'(er[0]), 0);
        send(16, 'h8000, 1'b0); neg(2);
        chk("after_abort_tv", int'(tv[0]), 4);
        chk("after_abort_sel", int'(sl[0]), 2);

        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            vld = 1'b1;
            din = ~din;
            rel = 4'b0001;
        end
        @(posedge clk); #1;
        vld = 1'b0;
        rel = '0;
        neg(1);
        chk("hold_tv", int'(tv[0]), 4);
        chk("hold_sel", int'(sl[0]), 2);
        chk("hold_busy", int'(bz[0]), 1);
        rls(4'b0100); neg(1);
        chk("hold_rel_tv", int'(tv[0]), 0);

        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            vld = 1'b1;
            din = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        neg(1);
        chk("midrst_tv", int'(tv[0]), 0);
        chk("midrst_sel", int'(sl[0]), 0);
        chk("midrst_err", int'(er[0]), 0);
        chk("midrst_busy", int'(bz[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vld = 1'b0;
        din = 1'b0;
        send(16, 'hC123, 1'b0); neg(2);
        chk("postrst_tv", int'(tv[0]), 8);
        chk("postrst_sel", int'(sl[0]), 3);
        rls(4'hF);

        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(12, 'h400, 1'b1); neg(2);
        chk("msb_tv", int'(tv[2]), 2);
        chk("msb_sel", int'(sl[2]), 1);
        chk("lsb12_tv", int'(tv[3]), 1);
        chk("lsb12_sel", int'(sl[3]), 0);

        neg(4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/addr_decoder_n.md
# addr_decoder_n

Parametrised serial address decoder for the serial bus interconnect, generalising the 3-target, 16-bit decoder. It shifts a serial address of `ADDR_WIDTH` bits off the bus in either bit order and matches it against `NUM_TARGETS` base/size windows. It grants exactly one target using highest-index priority, holds that grant until the bus releases it, and flags unmapped addresses with a decode-error pulse.

## Interface
- `NUM_TARGETS`, default 4: number of targets, range 1..8.
- `ADDR_WIDTH`, default 16: serial address length in bits, range 2..32.
- `TARGET_BASE`, default {16'hC000, 16'h8000, 16'h4000, 16'h0000}: packed `NUM_TARGETS*ADDR_WIDTH` vector; target i base at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `TARGET_SIZE`, default {32'd16384, 32'd4096, 32'd4096, 32'd2048}: packed `NUM_TARGETS*32` vector; target i size at `[i*32 +: 32]`; size 0 disables target i.
- `MSB_FIRST`, default 0: 0 means the first serial bit is addr[0]; 1 means the first serial bit is addr[ADDR_WIDTH-1].
- `SEL_W`, localparam: max(1, $clog2(NUM_TARGETS)).
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `bus_data_in  in  1`: serial address bit.
- `bus_data_in_valid  in  1`: bit strobe; a bit is sampled on each clk edge where it is high.
- `bus_mode  in  1`: 0 means address phase, 1 means data phase.
- `release_valids  in  NUM_TARGETS`: release strobes from the bus, one bit per target.
- `target_valid  out  NUM_TARGETS`: one-hot grant, or all zero.
- `sel  out  SEL_W`: binary index of the granted target; 0 when there is no grant.
- `decode_err  out  1`: one-cycle pulse when a completed address hits no target.
- `busy  out  1`: high in states SHIFT, DECODE and HOLD.

## Operation
- States: IDLE, SHIFT, DECODE, HOLD. Reset enters IDLE with shift register = 0, bit count = 0, `target_valid` = 0, `sel` = 0, `decode_err` = 0, `busy` = 0.
- IDLE, bit accepted when `bus_mode`=0 and `bus_data_in_valid`=1: shift in bit 0 and go to SHIFT with count = 1. If `ADDR_WIDTH` bits are complete, go straight to DECODE.
- SHIFT, accepted bit: shift it in and increment count. When count reaches `ADDR_WIDTH`, go to DECODE and clear count.
- SHIFT, `bus_data_in_valid`=0 or `bus_mode`=1: abort. Clear the shift register and count, return to IDLE, raise no error.
- Shift direction:
  - `MSB_FIRST`=0: sr <= {bit, sr[W-1:1]}.
  - `MSB_FIRST`=1: sr <= {sr[W-2:0], bit}.
- Match rule for target i: `TARGET_SIZE[i]` != 0 and base_i <= addr and addr < base_i + size_i.
  - Compare in `ADDR_WIDTH`+33 bits so windows reaching the top of the address space do not wrap.
  - A window whose base+size exceeds 2^`ADDR_WIDTH` is clipped at the top.
- DECODE, lasting one cycle, acts on the registered address:
  - Match vector nonzero: grant only the highest-index matching target, set `sel` to its index, go to HOLD.
  - Match vector zero: pulse `decode_err` for one cycle, return to IDLE.
- HOLD: ignore all bus bits; `target_valid` and `sel` are stable. When `release_valids` & `target_valid` is nonzero, clear the grant and `sel`, and return to IDLE.
- Release bits for targets not granted are ignored in every state.
- Reset asserted mid-operation from any state returns immediately to the reset values. A partial address is discarded.

## Timing
- All outputs are registered.
- Last address bit sampled at edge E: state becomes DECODE at E. `target_valid`, `sel` or `decode_err` update at E+1.
- Release sampled at edge R: `target_valid` = 0 and `sel` = 0 after R.
- The earliest next accepted bit is at R+1.
- Bits presented during DECODE (edge E+1) are dropped and do not start a new address.
- `busy` rises at the first accepted bit's edge and falls with the grant clear or the `decode_err` edge.
- Back-to-back addresses: the minimum gap from the last bit to the first bit of the next unmapped address is 2 cycles.

## Test plan
- Default parameters, LSB-first serial 0x4010 with valid held for 16 cycles: `target_valid`=4'b0010 and `sel`=1 one cycle after DECODE. Release 4'b0010: both clear next cycle.
- Serial 0xFFFF: `target_valid`=4'b1000, `sel`=3 (top-of-space window, no wrap). Serial 0x0800: `decode_err` pulses once, `target_valid` stays 0.
- Overlap priority with TARGET_BASE[1]=0x0000, TARGET_SIZE[1]=0x1000 and address 0x0100: only target 1 is granted, `sel`=1.
- Valid drops after 9 bits, then a full 0x8000 is sent: the abort leaves no grant and no error; the second address grants target 2.
- In HOLD, toggle bits and assert release 4'b0001 for a non-granted target: the grant is unchanged. Assert `rst_n` low mid-SHIFT: all outputs are 0 and the next full address decodes correctly.
- `MSB_FIRST`=1 with `ADDR_WIDTH`=12 and address 0x400: the target whose window contains 0x400 is granted; the same bits sent LSB-first (0x002) grant target 0.
